// File: rtl/astropix_spi_responder.sv
// AstroPix 2 chip-side SPI emulator.
// Oversamples the 5-wire SPI link in the system clock domain. Hit bytes
// from a first-word-fall-through TX FIFO are served as 2-bit pairs per SCK
// rise, and MOSI bytes captured on SCK fall are pushed to an RX FIFO.
//
// Handshakes: tx_rd_en_o and rx_wr_en_o are single-cycle strobes. A pop
// is issued only while tx_empty_i is low, and the head byte is consumed in
// that cycle. A push is issued only while rx_full_i is low, and
// rx_data_o is valid in the same cycle.
module astropix_spi_responder #(
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_csb,
  input  logic        spi_clock,
  input  logic        spi_mosi,
  output logic        spi_miso0,
  output logic        spi_miso1,
  output logic        interruptB,
  input  logic [7:0]  tx_data,
  input  logic        tx_empty,
  output logic        tx_rd_en,
  output logic [7:0]  rx_data,
  output logic        rx_wr_en,
  input  logic        rx_full,
  input  logic        clear_status,
  output logic        rx_overflow,
  output logic [15:0] frame_count
);

  // One extra stage beyond the synchronizer holds the previous sample for edge detection.
  localparam int DEPTH = SYNC_STAGES + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0]       csb_sync_q;
  logic [DEPTH-1:0]       sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [1:0]  pair_cnt_q, pair_cnt_d;
  logic [2:0]  rx_bit_cnt_q, rx_bit_cnt_d;
  logic        miso0_q, miso0_d;
  logic        miso1_q, miso1_d;
  logic        int_b_q, int_b_d;
  logic        tx_rd_en_q, tx_rd_en_d;
  logic        rx_wr_en_q, rx_wr_en_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_overflow_q, rx_overflow_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic sck_rise, sck_fall, csb_fall, csb_rise, mosi_sync;
  logic ovf_set, frame_done;

  // Input synchronizers; reset presets match an idle bus (csb high, sck low).
  always_ff @(posedge clock) begin
    if (reset) begin
      csb_sync_q  <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
    end else begin
      csb_sync_q  <= {csb_sync_q[DEPTH-2:0], spi_csb};
      sck_sync_q  <= {sck_sync_q[DEPTH-2:0], spi_clock};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  // Edges come from the newest synchronized sample and the one before it.
  always_comb begin
    sck_rise  =  sck_sync_q[DEPTH-2] & ~sck_sync_q[DEPTH-1];
    sck_fall  = ~sck_sync_q[DEPTH-2] &  sck_sync_q[DEPTH-1];
    csb_fall  = ~csb_sync_q[DEPTH-2] &  csb_sync_q[DEPTH-1];
    csb_rise  =  csb_sync_q[DEPTH-2] & ~csb_sync_q[DEPTH-1];
    mosi_sync =  mosi_sync_q[SYNC_STAGES-1];
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      pair_cnt_q    <= '0;
      rx_bit_cnt_q  <= '0;
      miso0_q       <= 1'b0;
      miso1_q       <= 1'b0;
      int_b_q       <= 1'b1;
      tx_rd_en_q    <= 1'b0;
      rx_wr_en_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_overflow_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      pair_cnt_q    <= pair_cnt_d;
      rx_bit_cnt_q  <= rx_bit_cnt_d;
      miso0_q       <= miso0_d;
      miso1_q       <= miso1_d;
      int_b_q       <= int_b_d;
      tx_rd_en_q    <= tx_rd_en_d;
      rx_wr_en_q    <= rx_wr_en_d;
      rx_data_q     <= rx_data_d;
      rx_overflow_q <= rx_overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Frame FSM: next state, shift registers, FIFO strobes and status.
  always_comb begin
    state_d      = state_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    pair_cnt_d   = pair_cnt_q;
    rx_bit_cnt_d = rx_bit_cnt_q;
    miso0_d      = miso0_q;
    miso1_d      = miso1_q;
    tx_rd_en_d   = 1'b0;
    rx_wr_en_d   = 1'b0;
    rx_data_d    = rx_data_q;
    ovf_set      = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso0_d = 1'b0;
        miso1_d = 1'b0;
        if (csb_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!tx_empty) begin
          tx_sr_d    = tx_data;
          tx_rd_en_d = 1'b1;
        end else begin
          tx_sr_d = IDLE_BYTE;
        end
        pair_cnt_d   = '0;
        rx_bit_cnt_d = '0;
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (csb_rise) begin
          // End of frame wins over any coincident SCK edge; partial bytes are dropped.
          frame_done = 1'b1;
          miso0_d    = 1'b0;
          miso1_d    = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          if (sck_rise) begin
            {miso0_d, miso1_d} = tx_sr_q[7:6];
            tx_sr_d            = {tx_sr_q[5:0], 2'b00};
            pair_cnt_d         = pair_cnt_q + 2'd1;
            if (pair_cnt_q == 2'd3) begin
              if (!tx_empty) begin
                tx_sr_d    = tx_data;
                tx_rd_en_d = 1'b1;
              end else begin
                tx_sr_d = IDLE_BYTE;
              end
            end
          end
          if (sck_fall) begin
            rx_sr_d      = {rx_sr_q[6:0], mosi_sync};
            rx_bit_cnt_d = rx_bit_cnt_q + 3'd1;
            if (rx_bit_cnt_q == 3'd7) begin
              if (!rx_full) begin
                rx_data_d  = {rx_sr_q[6:0], mosi_sync};
                rx_wr_en_d = 1'b1;
              end else begin
                ovf_set = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear in the same cycle as an overflow or frame end wins.
    if (clear_status) begin
      rx_overflow_d = 1'b0;
      frame_count_d = '0;
    end else begin
      rx_overflow_d = rx_overflow_q | ovf_set;
      frame_count_d = frame_count_q + {15'd0, frame_done};
    end

    // Interrupt mirrors FIFO emptiness but is held inactive during the load cycle.
    int_b_d = tx_empty | (state_d == ST_LOAD);
  end

  assign spi_miso0   = miso0_q;
  assign spi_miso1   = miso1_q;
  assign interruptB  = int_b_q;
  assign tx_rd_en    = tx_rd_en_q;
  assign rx_wr_en    = rx_wr_en_q;
  assign rx_data     = rx_data_q;
  assign rx_overflow = rx_overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_astropix_spi_responder.sv
// Testbench for astropix_spi_responder: a bit-banged SPI controller,
// a FWFT TX FIFO and an RX sink, checked against a frame-level model.
module tb_astropix_spi_responder;

  localparam logic [7:0] IDLE_BYTE = 8'hBC;
  localparam int         H_DEF     = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_csb = 1'b1;
  logic        spi_clock = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso0, spi_miso1, interruptB;
  logic [7:0]  tx_data;
  logic        tx_empty;
  logic        tx_rd_en;
  logic [7:0]  rx_data;
  logic        rx_wr_en;
  logic        rx_full = 1'b0;
  logic        clear_status = 1'b0;
  logic        rx_overflow;
  logic [15:0] frame_count;

  astropix_spi_responder #(.IDLE_BYTE(IDLE_BYTE), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset),
    .spi_csb(spi_csb), .spi_clock(spi_clock), .spi_mosi(spi_mosi),
    .spi_miso0(spi_miso0), .spi_miso1(spi_miso1), .interruptB(interruptB),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd_en(tx_rd_en),
    .rx_data(rx_data), .rx_wr_en(rx_wr_en), .rx_full(rx_full),
    .clear_status(clear_status), .rx_overflow(rx_overflow),
    .frame_count(frame_count)
  );

  // Clock
  always #5 clock = ~clock;

  // TX FIFO (first-word fall-through)
  logic [7:0] tx_mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign tx_data  = tx_mem[rd_ptr];
  assign tx_empty = (rd_ptr == wr_ptr);

  // FIFO-side monitor, sampled away from the active edge
  int   pop_cnt = 0, underflow_cnt = 0, dbl_rd = 0, dbl_wr = 0;
  logic rd_prev = 1'b0, wr_prev = 1'b0;
  logic [7:0] obs_rx_q[$];
  always @(negedge clock) begin
    if (tx_rd_en) begin
      pop_cnt++;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 8'd1;
      else underflow_cnt++;
    end
    if (tx_rd_en && rd_prev) dbl_rd++;
    if (rx_wr_en && wr_prev) dbl_wr++;
    rd_prev = tx_rd_en;
    wr_prev = rx_wr_en;
    if (rx_wr_en) obs_rx_q.push_back(rx_data);
  end

  // Reference model state
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic        exp_ovf = 1'b0;
  logic [15:0] exp_frames = 16'd0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
    exp_tx_q.push_back(b);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ovf"}, {31'd0, rx_overflow}, {31'd0, exp_ovf});
    check({tag, "_frames"}, {16'd0, frame_count}, {16'd0, exp_frames});
    check({tag, "_irq"}, {31'd0, interruptB}, (exp_tx_q.size() == 0) ? 32'd1 : 32'd0);
    check({tag, "_fifo_level"}, {24'd0, 8'(wr_ptr - rd_ptr)}, exp_tx_q.size());
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_rx_cnt"}, obs_rx_q.size(), exp_rx_q.size());
    while (obs_rx_q.size() > 0 && exp_rx_q.size() > 0)
      check({tag, "_rx_byte"}, {24'd0, obs_rx_q.pop_front()}, {24'd0, exp_rx_q.pop_front()});
    obs_rx_q.delete();
    exp_rx_q.delete();
  endtask

  // One csb-low frame of n SCK periods with half-period h clocks.
  task automatic run_frame(input string tag, input int n, input int h,
                           input logic [7:0] m0, input logic [7:0] m1,
                           input logic [7:0] m2, input logic [2:0] full_mask);
    logic [7:0] mb[3];
    logic [7:0] sb[8];
    logic [7:0] b;
    logic [1:0] ep;
    int k, exp_pops, pops0;
    mb[0] = m0; mb[1] = m1; mb[2] = m2;
    // Byte 0 loads at frame start, one more byte at every 4th rise.
    k = 1 + n / 4;
    exp_pops = 0;
    for (int j = 0; j < k; j++) begin
      if (exp_tx_q.size() > 0) begin
        sb[j] = exp_tx_q.pop_front();
        exp_pops++;
      end else begin
        sb[j] = IDLE_BYTE;
      end
    end
    pops0 = pop_cnt;
    spi_csb = 1'b0;
    wait_clks(h);
    check({tag, "_miso_pre"}, {30'd0, spi_miso0, spi_miso1}, 32'd0);
    for (int i = 0; i < n; i++) begin
      spi_mosi  = mb[i / 8][7 - (i % 8)];
      rx_full   = full_mask[i / 8];
      spi_clock = 1'b1;
      wait_clks(h);
      b  = sb[i / 4];
      ep = 2'((b >> (6 - 2 * (i % 4))) & 8'h03);
      check($sformatf("%s_pair%0d", tag, i), {30'd0, spi_miso0, spi_miso1}, {30'd0, ep});
      spi_clock = 1'b0;
      wait_clks(h);
    end
    rx_full = 1'b0;
    spi_csb = 1'b1;
    wait_clks(h + 4);
    for (int j = 0; j < n / 8; j++) begin
      if (full_mask[j]) exp_ovf = 1'b1;
      else exp_rx_q.push_back(mb[j]);
    end
    exp_frames = exp_frames + 16'd1;
    check({tag, "_pops"}, pop_cnt - pops0, exp_pops);
    check({tag, "_miso_post"}, {30'd0, spi_miso0, spi_miso1}, 32'd0);
    compare_rx(tag);
    check_status(tag);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    wait_clks(1);
    clear_status = 1'b0;
    exp_ovf = 1'b0;
    exp_frames = 16'd0;
    wait_clks(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso0"}, {31'd0, spi_miso0}, 32'd0);
    check({tag, "_miso1"}, {31'd0, spi_miso1}, 32'd0);
    check({tag, "_irq"}, {31'd0, interruptB}, 32'd1);
    check({tag, "_rd_en"}, {31'd0, tx_rd_en}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, rx_wr_en}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_ovf"}, {31'd0, rx_overflow}, 32'd0);
    check({tag, "_frames"}, {16'd0, frame_count}, 32'd0);
  endtask

  initial begin
    int n, h, np;
    logic [7:0] r0, r1, r2;
    logic [2:0] fm;

    // Reset
    reset = 1'b1;
    wait_clks(3);
    check_reset_values("rst");
    reset = 1'b0;
    wait_clks(4);

    // 1: two FIFO bytes over an 8-SCK frame
    push_tx(8'hA5);
    push_tx(8'h3C);
    wait_clks(3);
    check("t1_irq_pending", {31'd0, interruptB}, 32'd0);
    run_frame("t1", 8, H_DEF, 8'h00, 8'h00, 8'h00, 3'b000);

    // 2: empty FIFO serves the idle byte
    run_frame("t2", 4, H_DEF, 8'h00, 8'h00, 8'h00, 3'b000);

    // 3: two MOSI bytes
    run_frame("t3", 16, H_DEF, 8'h81, 8'h7E, 8'h00, 3'b000);

    // 4: RX full on the second byte, then clear
    run_frame("t4", 16, H_DEF, 8'h55, 8'hAA, 8'h00, 3'b010);
    pulse_clear();
    check_status("t4_clr");

    // 5: frame aborted after 5 SCK, next frame resumes on the next byte
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    wait_clks(2);
    run_frame("t5a", 5, H_DEF, 8'hF0, 8'h00, 8'h00, 3'b000);
    run_frame("t5b", 4, H_DEF, 8'h00, 8'h00, 8'h00, 3'b000);

    // 6: reset during SHIFT at the third SCK
    push_tx(8'hE7);
    wait_clks(2);
    spi_csb = 1'b0;
    wait_clks(H_DEF);
    for (int i = 0; i < 3; i++) begin
      spi_mosi  = 1'b1;
      spi_clock = 1'b1;
      wait_clks(H_DEF);
      if (i < 2) begin
        spi_clock = 1'b0;
        wait_clks(H_DEF);
      end
    end
    reset = 1'b1;
    spi_csb = 1'b1;
    spi_clock = 1'b0;
    spi_mosi = 1'b0;
    @(posedge clock);
    #1;
    check_reset_values("t6_rst");
    @(negedge clock);
    reset = 1'b0;
    void'(exp_tx_q.pop_front());
    exp_ovf = 1'b0;
    exp_frames = 16'd0;
    obs_rx_q.delete();
    exp_rx_q.delete();
    wait_clks(H_DEF);
    push_tx(8'h5A);
    wait_clks(2);
    run_frame("t6", 4, H_DEF, 8'h00, 8'h00, 8'h00, 3'b000);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      np = $urandom_range(0, 4);
      for (int p = 0; p < np; p++) push_tx(8'($urandom_range(0, 255)));
      n  = $urandom_range(1, 24);
      h  = $urandom_range(4, 9);
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      fm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      wait_clks(2);
      run_frame($sformatf("rnd%0d", f), n, h, r0, r1, r2, fm);
      if ($urandom_range(0, 5) == 0) begin
        pulse_clear();
        check_status($sformatf("rnd%0d_clr", f));
      end
    end

    check("rd_pulse_dbl", dbl_rd, 0);
    check("wr_pulse_dbl", dbl_wr, 0);
    check("tx_underflow", underflow_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
